// File: rtl/systolic_sequencer.sv
// Sequencer for one NxN output-stationary matrix multiply C = A x B.
// Loads A/B from the data banks, clears the PE array, feeds skewed
// operands into the array edges, then writes the results to the output bank.
module systolic_sequencer #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic [AW-1:0]     mem_a_addr,
  input  logic [DW-1:0]     mem_a_data,
  output logic [AW-1:0]     mem_b_addr,
  input  logic [DW-1:0]     mem_b_data,
  output logic [N*DW-1:0]   row_data,
  output logic [N*DW-1:0]   col_data,
  output logic              pe_en,
  output logic              pe_clr,
  input  logic [N*N*DW-1:0] pe_out,
  output logic              mem_o_we,
  output logic [AW-1:0]     mem_o_addr,
  output logic [DW-1:0]     mem_o_data
);

  localparam int NN = N * N;
  // One counter serves LOAD (0..NN), FEED (0..3N-3) and WB (0..NN-1).
  localparam int CW = $clog2(NN + 1);
  localparam int IW = $clog2(NN);

  localparam logic [CW-1:0] LoadLast = CW'(NN);
  localparam logic [CW-1:0] FeedLast = CW'(3 * N - 3);
  localparam logic [CW-1:0] WbLast   = CW'(NN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    FEED,
    WB,
    DONE
  } stateT;

  stateT           state;
  stateT           nextState;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nextCnt;

  // Row-major operand copies; address r*N+c holds element (r,c).
  logic [DW-1:0]   bufA [NN];
  logic [DW-1:0]   bufB [NN];
  logic [IW-1:0]   loadIdx;

  // Read data lags the address by one cycle, so slot cnt-1 is captured.
  assign loadIdx = IW'(cnt - 1'b1);

  // State and counter register; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Operand capture during LOAD; buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && cnt != '0) begin
      bufA[loadIdx] <= mem_a_data;
      bufB[loadIdx] <= mem_b_data;
    end
  end

  // Next-state and counter sequencing through the phases of one run.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    case (state)
      IDLE: begin
        if (ap_start) begin
          nextState = LOAD;
          nextCnt   = '0;
        end
      end
      LOAD: begin
        if (cnt == LoadLast) begin
          nextState = CLEAR;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + 1'b1;
        end
      end
      CLEAR: begin
        nextState = FEED;
        nextCnt   = '0;
      end
      FEED: begin
        if (cnt == FeedLast) begin
          nextState = WB;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + 1'b1;
        end
      end
      WB: begin
        if (cnt == WbLast) begin
          nextState = DONE;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + 1'b1;
        end
      end
      DONE: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  // Output decode from registered state and counter only.
  always_comb begin
    logic [IW-1:0] aIdx;
    logic [IW-1:0] bIdx;
    aIdx       = '0;
    bIdx       = '0;
    ap_done    = 1'b0;
    ap_idle    = 1'b0;
    mem_a_addr = '0;
    mem_b_addr = '0;
    row_data   = '0;
    col_data   = '0;
    pe_en      = 1'b0;
    pe_clr     = 1'b0;
    mem_o_we   = 1'b0;
    mem_o_addr = '0;
    mem_o_data = '0;
    case (state)
      IDLE: begin
        ap_idle = 1'b1;
      end
      LOAD: begin
        if (cnt < LoadLast) begin
          mem_a_addr = AW'(cnt);
          mem_b_addr = AW'(cnt);
        end
      end
      CLEAR: begin
        pe_clr = 1'b1;
      end
      FEED: begin
        pe_en = 1'b1;
        // Row i carries A[i][t-i] and column j carries B[t-j][j] so that
        // operand k meets at PE(i,j) on step k+i+j.
        for (int i = 0; i < N; i++) begin
          if (cnt >= CW'(i) && cnt < CW'(i + N)) begin
            aIdx = IW'(i * N + int'(cnt) - i);
            row_data[i*DW +: DW] = bufA[aIdx];
          end
          if (cnt >= CW'(i) && cnt < CW'(i + N)) begin
            bIdx = IW'((int'(cnt) - i) * N + i);
            col_data[i*DW +: DW] = bufB[bIdx];
          end
        end
      end
      WB: begin
        mem_o_we   = 1'b1;
        mem_o_addr = AW'(cnt);
        mem_o_data = pe_out[int'(cnt)*DW +: DW];
      end
      DONE: begin
        ap_done = 1'b1;
      end
      default: begin
        ap_idle = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural 4x4 PE grid
// and synchronous-read A/B banks plus an output bank.
module tb_systolic_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic [15:0]   mem_a_addr;
  logic [15:0]   mem_a_data;
  logic [15:0]   mem_b_addr;
  logic [15:0]   mem_b_data;
  logic [63:0]   row_data;
  logic [63:0]   col_data;
  logic          pe_en;
  logic          pe_clr;
  logic [255:0]  pe_out;
  logic          mem_o_we;
  logic [15:0]   mem_o_addr;
  logic [15:0]   mem_o_data;

  logic [15:0]   memA [16];
  logic [15:0]   memB [16];
  logic [15:0]   memO [16];
  logic [15:0]   expC [16];

  logic [15:0]   acc  [4][4];
  logic [15:0]   aReg [4][4];
  logic [15:0]   bReg [4][4];

  int vectors     = 0;
  int miscompares = 0;

  int doneCount;
  int doneCyc [2];
  int idleAfterDone;
  int secondLoadCyc;
  int clrCount;
  int clrCyc;
  int enCount;
  int enFirst;
  int enLast;
  int writeCount;
  int endCyc;
  logic postIdle;
  logic postEn;
  logic postWe;
  logic [15:0] rowSnap [10][4];
  logic [15:0] colSnap [10][4];

  systolic_sequencer #(.N(4), .DW(16), .AW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .mem_a_addr (mem_a_addr),
    .mem_a_data (mem_a_data),
    .mem_b_addr (mem_b_addr),
    .mem_b_data (mem_b_data),
    .row_data   (row_data),
    .col_data   (col_data),
    .pe_en      (pe_en),
    .pe_clr     (pe_clr),
    .pe_out     (pe_out),
    .mem_o_we   (mem_o_we),
    .mem_o_addr (mem_o_addr),
    .mem_o_data (mem_o_data)
  );

  always #5 clk = ~clk;

  // Banks: reads return data one cycle after the address, writes are synchronous.
  always @(posedge clk) begin
    mem_a_data <= memA[mem_a_addr[3:0]];
    mem_b_data <= memB[mem_b_addr[3:0]];
    if (mem_o_we) memO[mem_o_addr[3:0]] <= mem_o_data;
  end

  // Output-stationary PE grid: A shifts right, B shifts down, 16-bit wrapping MAC.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [15:0] aIn;
        logic [15:0] bIn;
        logic [31:0] prod;
        aIn  = (j == 0) ? row_data[i*16 +: 16] : aReg[i][j-1];
        bIn  = (i == 0) ? col_data[j*16 +: 16] : bReg[i-1][j];
        prod = aIn * bIn;
        if (pe_clr) begin
          acc[i][j]  <= '0;
          aReg[i][j] <= '0;
          bReg[i][j] <= '0;
        end else if (pe_en) begin
          acc[i][j]  <= acc[i][j] + prod[15:0];
          aReg[i][j] <= aIn;
          bReg[i][j] <= bIn;
        end
      end
    end
  end

  // Pack the accumulators into the flat result bus.
  always_comb begin
    pe_out = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pe_out[(i*4+j)*16 +: 16] = acc[i][j];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic computeExpected();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [15:0] s;
        logic [31:0] p;
        s = '0;
        for (int k = 0; k < 4; k++) begin
          p = memA[i*4+k] * memB[k*4+j];
          s = s + p[15:0];
        end
        expC[i*4+j] = s;
      end
  endtask

  // Launches a run (cycle 0 = cycle ap_start is sampled) and records what happens.
  task automatic applyStimulus(input bit holdStart, input int pulseCyc, input int rstCyc);
    computeExpected();
    doneCount = 0; doneCyc[0] = -1; doneCyc[1] = -1; idleAfterDone = -1;
    secondLoadCyc = -1; clrCount = 0; clrCyc = -1; enCount = 0;
    enFirst = -1; enLast = -1; writeCount = 0; endCyc = -1;
    postIdle = 1'b0; postEn = 1'b1; postWe = 1'b1;
    @(negedge clk);
    ap_start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (ap_done) begin
        if (doneCount < 2) doneCyc[doneCount] = c;
        doneCount++;
      end
      if (doneCount >= 1 && c == doneCyc[0] + 1) idleAfterDone = int'(ap_idle);
      if (doneCount >= 1 && secondLoadCyc < 0 && c > doneCyc[0] && !ap_idle) secondLoadCyc = c;
      if (pe_clr) begin
        clrCount++;
        clrCyc = c;
      end
      if (pe_en) begin
        if (enFirst < 0) enFirst = c;
        enLast = c;
        if (enCount < 10)
          for (int i = 0; i < 4; i++) begin
            rowSnap[enCount][i] = row_data[i*16 +: 16];
            colSnap[enCount][i] = col_data[i*16 +: 16];
          end
        enCount++;
      end
      if (mem_o_we) begin
        checkOutput("wrAddr", 64'(mem_o_addr), 64'(writeCount % 16));
        checkOutput("wrData", 64'(mem_o_data), 64'(expC[writeCount % 16]));
        writeCount++;
      end
      if (rstCyc > 0 && c == rstCyc + 1) begin
        postIdle = ap_idle;
        postEn   = pe_en;
        postWe   = mem_o_we;
        rst      = 1'b0;
      end
      if (rstCyc > 0 && c == rstCyc) rst = 1'b1;
      ap_start = (holdStart && doneCount < 2) || (c == pulseCyc);
      if (rstCyc > 0) begin
        if (c == rstCyc + 20) begin
          endCyc = c;
          break;
        end
      end else if (doneCount == (holdStart ? 2 : 1) && c == doneCyc[doneCount-1] + 1) begin
        endCyc = c;
        break;
      end
    end
    ap_start = 1'b0;
    rst      = 1'b0;
    checkOutput("runFinished", 64'(endCyc >= 0), 64'd1);
  endtask

  initial begin
    rst      = 1'b1;
    ap_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      memA[i] = '0;
      memB[i] = '0;
      memO[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstIdle",  64'(ap_idle), 64'd1);
    checkOutput("rstDone",  64'(ap_done), 64'd0);
    checkOutput("rstPeEn",  64'(pe_en), 64'd0);
    checkOutput("rstPeClr", 64'(pe_clr), 64'd0);
    checkOutput("rstWe",    64'(mem_o_we), 64'd0);
    checkOutput("rstAddrA", 64'(mem_a_addr), 64'd0);
    checkOutput("rstRows",  row_data, 64'd0);
    rst = 1'b0;

    $display("[TB] identity A times counting B");
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        memA[r*4+c] = (r == c) ? 16'd1 : 16'd0;
        memB[r*4+c] = 16'(r*4 + c + 1);
      end
    applyStimulus(1'b0, 0, 0);
    checkOutput("doneCycle", 64'(doneCyc[0]), 64'd45);
    checkOutput("idleAfter", 64'(idleAfterDone), 64'd1);
    checkOutput("doneCount", 64'(doneCount), 64'd1);
    checkOutput("writeCount", 64'(writeCount), 64'd16);
    for (int i = 0; i < 16; i++) checkOutput("identOut", 64'(memO[i]), 64'(i + 1));
    checkOutput("colT3j0", 64'(colSnap[3][0]), 64'd13);
    checkOutput("colT3j1", 64'(colSnap[3][1]), 64'd10);
    checkOutput("colT3j2", 64'(colSnap[3][2]), 64'd7);
    checkOutput("colT3j3", 64'(colSnap[3][3]), 64'd4);

    $display("[TB] all-ones operands");
    for (int i = 0; i < 16; i++) begin
      memA[i] = 16'd1;
      memB[i] = 16'd1;
    end
    applyStimulus(1'b0, 0, 0);
    for (int i = 0; i < 16; i++) checkOutput("onesOut", 64'(memO[i]), 64'd4);
    checkOutput("enCount", 64'(enCount), 64'd10);
    checkOutput("enSpan", 64'(enLast - enFirst), 64'd9);
    checkOutput("clrCount", 64'(clrCount), 64'd1);
    checkOutput("clrBeforeEn", 64'(clrCyc), 64'(enFirst - 1));

    $display("[TB] skew pattern");
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        memA[r*4+c] = 16'(16*r + c);
        memB[r*4+c] = (r == c) ? 16'd1 : 16'd0;
      end
    applyStimulus(1'b0, 0, 0);
    checkOutput("rowT3r0", 64'(rowSnap[3][0]), 64'h03);
    checkOutput("rowT3r1", 64'(rowSnap[3][1]), 64'h12);
    checkOutput("rowT3r2", 64'(rowSnap[3][2]), 64'h21);
    checkOutput("rowT3r3", 64'(rowSnap[3][3]), 64'h30);
    checkOutput("rowT4r0", 64'(rowSnap[4][0]), 64'h00);
    checkOutput("rowT6r0", 64'(rowSnap[6][0]), 64'h00);
    checkOutput("rowT6r1", 64'(rowSnap[6][1]), 64'h00);
    checkOutput("rowT6r2", 64'(rowSnap[6][2]), 64'h00);
    checkOutput("rowT6r3", 64'(rowSnap[6][3]), 64'h33);
    for (int i = 0; i < 16; i++) checkOutput("skewOut", 64'(memO[i]), 64'(16*(i/4) + (i%4)));

    $display("[TB] ap_start held high for back-to-back runs");
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        memA[r*4+c] = (r == c) ? 16'd1 : 16'd0;
        memB[r*4+c] = 16'(r*4 + c + 1);
      end
    applyStimulus(1'b1, 0, 0);
    checkOutput("holdDone1", 64'(doneCyc[0]), 64'd45);
    checkOutput("holdLoad2", 64'(secondLoadCyc), 64'd47);
    checkOutput("holdDone2", 64'(doneCyc[1]), 64'd91);
    checkOutput("holdDoneCnt", 64'(doneCount), 64'd2);
    checkOutput("holdWrites", 64'(writeCount), 64'd32);

    $display("[TB] ap_start pulse during FEED");
    applyStimulus(1'b0, 22, 0);
    checkOutput("pulseDone", 64'(doneCyc[0]), 64'd45);
    checkOutput("pulseDoneCnt", 64'(doneCount), 64'd1);
    checkOutput("pulseEnCount", 64'(enCount), 64'd10);

    $display("[TB] reset during FEED");
    applyStimulus(1'b0, 0, 24);
    checkOutput("postRstIdle", 64'(postIdle), 64'd1);
    checkOutput("postRstEn", 64'(postEn), 64'd0);
    checkOutput("postRstWe", 64'(postWe), 64'd0);
    checkOutput("postRstDone", 64'(doneCount), 64'd0);
    checkOutput("postRstEnCnt", 64'(enCount), 64'd6);
    checkOutput("postRstWrites", 64'(writeCount), 64'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        memA[r*4+c] = 16'd1;
        memB[r*4+c] = (r == c) ? 16'd1 : 16'd0;
      end
    applyStimulus(1'b0, 0, 0);
    checkOutput("reloadDone", 64'(doneCyc[0]), 64'd45);
    for (int i = 0; i < 16; i++) checkOutput("reloadOut", 64'(memO[i]), 64'd1);

    $display("[TB] saturated operands");
    for (int i = 0; i < 16; i++) begin
      memA[i] = 16'hFFFF;
      memB[i] = 16'hFFFF;
    end
    applyStimulus(1'b0, 0, 0);
    checkOutput("ffffWrites", 64'(writeCount), 64'd16);
    for (int i = 0; i < 16; i++) checkOutput("ffffOut", 64'(memO[i]), 64'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
